uart_transmit_arbiter: RTL

//  Shares one uart_transmit byte port between N_REQ requesters in the UART sim transactor.

---
 rtl/uart_transmit_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_transmit_arbiter.sv
// Round-robin, packet-based arbiter sharing one UART transmit byte port.
// Optional owner header byte is enabled by defining UART_TX_ARB_HEADER_EN.
module uart_transmit_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [N_REQ*8-1:0] i_data,
    input  logic [N_REQ-1:0]   i_data_valid,
    input  logic [N_REQ-1:0]   i_data_last,
    output logic [N_REQ-1:0]   o_data_ready,
    output logic [7:0]         o_data,
    output logic               o_data_valid,
    input  logic               i_data_ready,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

`ifdef UART_TX_ARB_HEADER_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_HEADER = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    w_owner_nxt;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_ptr_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_count_inc;
    logic [PW-1:0]    w_ptr_wrap;

    logic             w_found;
    logic [PW-1:0]    w_sel;
    logic [PW:0]      w_idx;
    logic             w_xfer;

    // Search ptr, ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(N_REQ)) begin
                w_idx = w_idx - (PW+1)'(N_REQ);
            end
            if (!w_found && i_data_valid[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[PW-1:0];
            end
        end
    end

    assign w_count_inc = r_count + CW'(1);
    assign w_ptr_wrap  = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_count_nxt  = r_count;
        w_xfer       = 1'b0;
        o_data       = 8'h00;
        o_data_valid = 1'b0;
        o_data_ready = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = N_REQ'(1) << w_sel;
                    w_owner_nxt = w_sel;
`ifdef UART_TX_ARB_HEADER_EN
                    w_state_nxt = S_HEADER;
`else
                    w_state_nxt = S_GRANT;
`endif
                end
            end
`ifdef UART_TX_ARB_HEADER_EN
            // Header byte tags the packet with its owner; not a burst byte.
            S_HEADER: begin
                o_data       = 8'hF0 | 8'(r_owner);
                o_data_valid = 1'b1;
                if (i_data_ready) begin
                    w_state_nxt = S_GRANT;
                end
            end
`endif
            S_GRANT: begin
                o_data                = i_data[{r_owner, 3'b000} +: 8];
                o_data_valid          = i_data_valid[r_owner];
                o_data_ready[r_owner] = i_data_ready;
                w_xfer                = i_data_valid[r_owner] && i_data_ready;
                if (w_xfer) begin
                    w_count_nxt = w_count_inc;
                    if (i_data_last[r_owner] ||
                        w_count_inc == CW'(MAX_BURST)) begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                        w_count_nxt = '0;
                        w_ptr_nxt   = w_ptr_wrap;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state != S_IDLE);

endmodule
